// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel 3x3 window generator.
// Holds parameter defaults, the FSM state encoding and the window indexing.
package sobel_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_MAX_W  = 640;
  localparam int DEF_ADDR_W = 10;

  // Window geometry: data[3*row + col], row 0 oldest, col 0 leftmost.
  localparam int WIN_DIM = 3;
  localparam int WIN_N   = WIN_DIM * WIN_DIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Frame geometry is usable only if a full 3x3 window fits and a line fits the RAM.
  function automatic logic cfg_legal(input logic [15:0] w, input logic [15:0] h,
                                     input logic [15:0] max_w);
    return (w >= 16'd3) && (w <= max_w) && (h >= 16'd3);
  endfunction

endpackage

// File: rtl/sobel_window_gen_line_buf.sv
// One line of pixel history: 1R1W RAM, synchronous write, asynchronous read.
// Reading and writing the same address in a cycle returns the old contents.
module line_buf #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MAX_W];

  // Store the incoming pixel at its column.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel 3x3 window generator: raster pixel stream in, 3x3 windows out.
// Optional macro WINGEN_SOF_EN adds a pix_sof input that resynchronises
// the frame origin to the flagged pixel.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_W  = DEF_MAX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [15:0]       W,
  input  logic [15:0]       H,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
`ifdef WINGEN_SOF_EN
  input  logic              pix_sof,
`endif
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data5,
  output logic [DATA_W-1:0] data6,
  output logic [DATA_W-1:0] data7,
  output logic [DATA_W-1:0] data8,
  output logic              win_valid,
  output logic [15:0]       W_counter,
  output logic [15:0]       H_counter,
  output logic              done,
  output logic              cfg_err
);

  state_e state_q, state_d;

  logic [15:0] w_q, h_q, wm1_q, hm1_q;
  logic [15:0] col_q, row_q;
  logic [15:0] col_eff, row_eff;
  logic        done_q, cfg_err_q, win_valid_q;
  logic [15:0] wcnt_q, hcnt_q;

  logic [WIN_N-1:0][DATA_W-1:0] sh_q, sh_d;
  logic [WIN_N-1:0][DATA_W-1:0] win_q;

  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  logic start_take, accept, sof, emit, last_pix, cfg_ok;

`ifdef WINGEN_SOF_EN
  assign sof = pix_sof;
`else
  assign sof = 1'b0;
`endif

  assign pix_ready  = (state_q == ST_RUN);
  assign accept     = pix_ready & pix_valid;
  assign start_take = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign cfg_ok     = cfg_legal(w_q, h_q, 16'(MAX_W));

  // A resync pixel is treated as position (0,0) of a fresh frame.
  assign col_eff  = sof ? 16'd0 : col_q;
  assign row_eff  = sof ? 16'd0 : row_q;
  assign emit     = accept & (row_eff >= 16'd2) & (col_eff >= 16'd2);
  assign last_pix = accept & ~sof & (col_q == wm1_q) & (row_q == hm1_q);

  line_buf #(.DATA_W(DATA_W), .MAX_W(MAX_W), .ADDR_W(ADDR_W)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_eff[ADDR_W-1:0]),
    .wdata_i (pix_data),
    .rdata_o (lb0_rd)
  );

  line_buf #(.DATA_W(DATA_W), .MAX_W(MAX_W), .ADDR_W(ADDR_W)) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_eff[ADDR_W-1:0]),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame start, geometry check, run until the last pixel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = cfg_ok ? ST_RUN : ST_DONE;
      ST_RUN:   if (last_pix) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_CHECK;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shift array next value: move left one column, new right column from history + pixel.
  always_comb begin
    sh_d = sh_q;
    for (int r = 0; r < WIN_DIM; r++) begin
      sh_d[WIN_DIM*r]     = sh_q[WIN_DIM*r + 1];
      sh_d[WIN_DIM*r + 1] = sh_q[WIN_DIM*r + 2];
    end
    sh_d[2] = lb1_rd;
    sh_d[5] = lb0_rd;
    sh_d[8] = pix_data;
  end

  // Shift array advances only on accepted pixels; it is never cleared between rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_q <= sh_d;
    end
  end

  // Frame geometry latch, raster position and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q       <= '0;
      h_q       <= '0;
      wm1_q     <= '0;
      hm1_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (start_take) begin
        w_q       <= W;
        h_q       <= H;
        wm1_q     <= W - 16'd1;
        hm1_q     <= H - 16'd1;
        col_q     <= '0;
        row_q     <= '0;
        done_q    <= 1'b0;
        cfg_err_q <= 1'b0;
      end else if (state_q == ST_CHECK) begin
        if (!cfg_ok) begin
          done_q    <= 1'b1;
          cfg_err_q <= 1'b1;
        end
      end else if (accept) begin
        if (sof) begin
          col_q <= 16'd1;
          row_q <= '0;
        end else if (col_q == wm1_q) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
        if (last_pix) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // Window output registers: load one cycle after a pixel completes a window, hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid_q <= 1'b0;
      win_q       <= '0;
      wcnt_q      <= '0;
      hcnt_q      <= '0;
    end else begin
      win_valid_q <= emit;
      if (emit) begin
        win_q  <= sh_d;
        wcnt_q <= col_eff - 16'd2;
        hcnt_q <= row_eff - 16'd2;
      end
    end
  end

  assign data0     = win_q[0];
  assign data1     = win_q[1];
  assign data2     = win_q[2];
  assign data3     = win_q[3];
  assign data4     = win_q[4];
  assign data5     = win_q[5];
  assign data6     = win_q[6];
  assign data7     = win_q[7];
  assign data8     = win_q[8];
  assign win_valid = win_valid_q;
  assign W_counter = wcnt_q;
  assign H_counter = hcnt_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: table of frame configurations plus hand-written
// sequences for reset mid-frame, hand-computed windows and (optionally) resync.
module tb_sobel_window_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] Wi, Hi;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
`ifdef WINGEN_SOF_EN
  logic        pix_sof;
`endif
  logic [7:0]  dv [9];
  logic        win_valid;
  logic [15:0] W_counter, H_counter;
  logic        done, cfg_err;

  always #5 clk = ~clk;

  sobel_window_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .W         (Wi),
    .H         (Hi),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
`ifdef WINGEN_SOF_EN
    .pix_sof   (pix_sof),
`endif
    .data0     (dv[0]),
    .data1     (dv[1]),
    .data2     (dv[2]),
    .data3     (dv[3]),
    .data4     (dv[4]),
    .data5     (dv[5]),
    .data6     (dv[6]),
    .data7     (dv[7]),
    .data8     (dv[8]),
    .win_valid (win_valid),
    .W_counter (W_counter),
    .H_counter (H_counter),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  typedef struct packed {
    logic [8:0][7:0] d;
    logic [15:0]     wc;
    logic [15:0]     hc;
  } win_t;

  typedef struct {
    int w;
    int h;
    int gap;
    int pat;
    int base;
    bit err;
    int nwin;
  } vec_t;

  win_t wq[$];
  int   img [0:4095];
  int   checks = 0;
  int   errors = 0;

  // Collect every emitted window.
  always @(negedge clk) begin
    if (rstn && win_valid) begin
      win_t t;
      for (int k = 0; k < 9; k++) t.d[k] = dv[k];
      t.wc = W_counter;
      t.hc = H_counter;
      wq.push_back(t);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int w, input int h, input int gap, input int pat,
                           input int base, input int sof_idx, input bit exp_err,
                           input int exp_win);
    int   n, idx, cyc, o;
    bit   v, rdy;
    win_t e;
    for (int i = 0; i < 4096; i++)
      img[i] = (pat == 0) ? ((base + i) & 255) : int'($urandom_range(0, 255));
    wq.delete();
    @(negedge clk);
    Wi = 16'(w); Hi = 16'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0; Wi = 16'd1; Hi = 16'd1;
    chk("done_clear", done, 0);
    chk("cfg_err_clear", cfg_err, 0);
    @(negedge clk);
    if (exp_err) begin
      chk("err_done", done, 1);
      chk("err_cfg_err", cfg_err, 1);
      repeat (3) @(negedge clk);
      chk("err_ready", pix_ready, 0);
      chk("err_nwin", wq.size(), 0);
      return;
    end
    chk("run_ready", pix_ready, 1);
    chk("run_cfg_err", cfg_err, 0);
    o   = (sof_idx >= 0) ? sof_idx : 0;
    n   = o + w * h;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 20000) begin
      v = (gap == 0) || ($urandom_range(0, 99) >= gap);
      pix_valid = v;
      pix_data  = img[idx][7:0];
`ifdef WINGEN_SOF_EN
      pix_sof   = (idx == sof_idx);
`endif
      rdy = pix_ready;
      @(negedge clk);
      if (v && rdy) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
`ifdef WINGEN_SOF_EN
    pix_sof = 1'b0;
`endif
    if (idx < n) begin
      chk("timeout_pixels", idx, n);
      return;
    end
    chk("done_after_last", done, 1);
    chk("last_win_valid", win_valid, 1);
    repeat (2) @(negedge clk);
    chk("ready_after_done", pix_ready, 0);
    chk("nwin", wq.size(), exp_win);
    for (int r = 0; r <= h - 3; r++) begin
      for (int c = 0; c <= w - 3; c++) begin
        int k;
        k = r * (w - 2) + c;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.d[3*i+j] = img[o + (r + i) * w + c + j][7:0];
        e.wc = 16'(c);
        e.hc = 16'(r);
        if (k < wq.size()) chk("window", wq[k], e);
      end
    end
  endtask

  vec_t tbl [8];

  initial begin
    win_t e;
    tbl[0] = '{w:5,   h:4,  gap:0,  pat:0, base:0,   err:1'b0, nwin:6};
    tbl[1] = '{w:2,   h:10, gap:0,  pat:0, base:0,   err:1'b1, nwin:0};
    tbl[2] = '{w:640, h:3,  gap:50, pat:1, base:0,   err:1'b0, nwin:638};
    tbl[3] = '{w:4,   h:4,  gap:0,  pat:0, base:30,  err:1'b0, nwin:4};
    tbl[4] = '{w:4,   h:4,  gap:25, pat:1, base:0,   err:1'b0, nwin:4};
    tbl[5] = '{w:3,   h:3,  gap:0,  pat:0, base:200, err:1'b0, nwin:1};
    tbl[6] = '{w:641, h:3,  gap:0,  pat:0, base:0,   err:1'b1, nwin:0};
    tbl[7] = '{w:5,   h:2,  gap:0,  pat:0, base:0,   err:1'b1, nwin:0};

    rstn = 1'b0; start = 1'b0; Wi = '0; Hi = '0;
    pix_valid = 1'b0; pix_data = '0;
`ifdef WINGEN_SOF_EN
    pix_sof = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_counters", {W_counter, H_counter}, 0);
    chk("rst_data0", dv[0], 0);
    rstn = 1'b1;

    for (int t = 0; t < 8; t++)
      run_frame(tbl[t].w, tbl[t].h, tbl[t].gap, tbl[t].pat, tbl[t].base, -1,
                tbl[t].err, tbl[t].nwin);

    // Hand-computed ramp frame 5x4.
    run_frame(5, 4, 0, 0, 0, -1, 1'b0, 6);
    if (wq.size() >= 6) begin
      e.d = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
      e.wc = 16'd0; e.hc = 16'd0;
      chk("t1_first", wq[0], e);
      e.d = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
      e.wc = 16'd2; e.hc = 16'd1;
      chk("t1_last", wq[5], e);
    end

    // Asynchronous reset in the middle of row 2, then a fresh 4x3 frame.
    for (int i = 0; i < 4096; i++) img[i] = (100 + i) & 255;
    @(negedge clk);
    Wi = 16'd5; Hi = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      pix_valid = 1'b1;
      pix_data  = img[i][7:0];
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk("t4_win_before_rst", {win_valid, dv[0], dv[8]}, {1'b1, 8'd100, 8'd112});
    #2 rstn = 1'b0;
    #1;
    chk("t4_async_ctrl", {win_valid, done, cfg_err, pix_ready}, 0);
    chk("t4_async_cnt", {W_counter, H_counter}, 0);
    chk("t4_async_data", {dv[0], dv[1], dv[2], dv[3], dv[4], dv[5], dv[6], dv[7], dv[8]}, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(4, 3, 0, 0, 50, -1, 1'b0, 2);

`ifdef WINGEN_SOF_EN
    // Resync at frame pixel 7: origin moves, first window ends on pixel 19.
    run_frame(5, 4, 0, 0, 0, 7, 1'b0, 6);
    if (wq.size() > 0) chk("t6_first_br", wq[0].d[8], 8'd19);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
